// File: rtl/cache_arbiter_adaptor_pkg.sv
// Shared types and sizing for the I/D cache to physical-memory arbiter.
package rv32i_types;

    localparam int unsigned LINE_W     = 256;
    localparam int unsigned BEAT_W     = 64;
    localparam int unsigned BEATS      = 4;
    localparam int unsigned BEAT_IDX_W = $clog2(BEATS);
    localparam int unsigned ADDR_W     = 32;

    // Line-aligned address: the low five bits address bytes within a 32-byte line.
    localparam logic [ADDR_W-1:0] LINE_ADDR_MASK = 32'hFFFF_FFE0;

    typedef enum logic [2:0] {
        IDLE,
        I_READ,
        D_READ,
        D_WRITE,
        DONE
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter_adaptor_beat_buf.sv
// One cache line register that can be loaded whole or one memory beat at a time,
// and presents the beat selected by beat_idx.
module cacheline_beat_buf
    import rv32i_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_line,
    input  logic [LINE_W-1:0]     line_in,
    input  logic                  load_beat,
    input  logic [BEAT_IDX_W-1:0] beat_idx,
    input  logic [BEAT_W-1:0]     beat_in,
    output logic [LINE_W-1:0]     line,
    output logic [BEAT_W-1:0]     beat_out
);

    // Whole-line load takes priority over a single-beat update.
    always_ff @(posedge clk) begin
        if (rst) begin
            line <= '0;
        end else if (load_line) begin
            line <= line_in;
        end else if (load_beat) begin
            line[beat_idx*BEAT_W +: BEAT_W] <= beat_in;
        end
    end

    assign beat_out = line[beat_idx*BEAT_W +: BEAT_W];

endmodule

// File: rtl/cache_arbiter_adaptor.sv
// Arbitrates I-cache and D-cache line requests onto one 4-beat, 64-bit burst
// memory port. Reads are assembled into a shared line buffer; writebacks are
// latched at grant and streamed out beat by beat.
module cache_arbiter_adaptor
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t            state;
    logic [BEAT_IDX_W-1:0] beat_cnt;
    // Winner of the most recent contested arbitration (1 = D-cache).
    logic                  last_grant_d;

    logic i_req;
    logic d_req;
    logic contested;
    logic grant_d;
    logic in_burst;
    logic beat_fire;
    logic last_beat;
    logic wr_load;
    logic rd_load_beat;

    logic [LINE_W-1:0] rd_line;
    logic [BEAT_W-1:0] rd_beat_unused;
    logic [LINE_W-1:0] wr_line_unused;

    assign i_req        = i_pmem_read;
    assign d_req        = d_pmem_read | d_pmem_write;
    assign contested    = i_req & d_req;
    assign grant_d      = d_req & (~i_req | ~last_grant_d);
    assign in_burst     = (state == I_READ) || (state == D_READ) || (state == D_WRITE);
    assign beat_fire    = in_burst & mem_resp;
    assign last_beat    = (beat_cnt == BEAT_IDX_W'(BEATS - 1));
    assign wr_load      = (state == IDLE) & grant_d & d_pmem_write;
    assign rd_load_beat = beat_fire & (state != D_WRITE);

    assign i_pmem_rdata = rd_line;
    assign d_pmem_rdata = rd_line;

    // Read line assembly: one slot per returned beat, held until the next read.
    cacheline_beat_buf u_rd_buf (
        .clk       (clk),
        .rst       (rst),
        .load_line (1'b0),
        .line_in   ('0),
        .load_beat (rd_load_beat),
        .beat_idx  (beat_cnt),
        .beat_in   (mem_rdata),
        .line      (rd_line),
        .beat_out  (rd_beat_unused)
    );

    // Writeback line captured at grant and presented one beat at a time.
    cacheline_beat_buf u_wr_buf (
        .clk       (clk),
        .rst       (rst),
        .load_line (wr_load),
        .line_in   (d_pmem_wdata),
        .load_beat (1'b0),
        .beat_idx  (beat_cnt),
        .beat_in   ('0),
        .line      (wr_line_unused),
        .beat_out  (mem_wdata)
    );

    // Arbitration, burst sequencing and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            last_grant_d <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_address  <= '0;
            i_pmem_resp  <= 1'b0;
            d_pmem_resp  <= 1'b0;
        end else begin
            i_pmem_resp <= 1'b0;
            d_pmem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (contested) begin
                        last_grant_d <= grant_d;
                    end
                    if (grant_d) begin
                        mem_address <= d_pmem_address & LINE_ADDR_MASK;
                        if (d_pmem_write) begin
                            state     <= D_WRITE;
                            mem_write <= 1'b1;
                        end else begin
                            state    <= D_READ;
                            mem_read <= 1'b1;
                        end
                    end else if (i_req) begin
                        mem_address <= i_pmem_address & LINE_ADDR_MASK;
                        state       <= I_READ;
                        mem_read    <= 1'b1;
                    end
                end
                I_READ, D_READ, D_WRITE: begin
                    if (mem_resp) begin
                        beat_cnt <= beat_cnt + BEAT_IDX_W'(1);
                        if (last_beat) begin
                            state     <= DONE;
                            mem_read  <= 1'b0;
                            mem_write <= 1'b0;
                            if (state == I_READ) begin
                                i_pmem_resp <= 1'b1;
                            end else begin
                                d_pmem_resp <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_arbiter_adaptor.sv
// Scoreboard bench: stimulus pushes the expected bursts in predicted grant order,
// a burst memory model answers the port, and a monitor checks every burst.
module tb_cache_arbiter_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         mem_resp;

    cache_arbiter_adaptor dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    always #5 clk = ~clk;

    // kind: 0 = I read, 1 = D read, 2 = D write
    typedef struct {
        int           kind;
        logic [31:0]  addr;
        logic [255:0] line;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         cur;
    int           checks = 0;
    int           errors = 0;
    bit           last_d;           // model: D won the last contested grant
    logic [255:0] mem_store [logic [31:0]];
    int           mbeat;
    int           gap_left;
    bit           use_pat;
    bit           stray_req;
    int           gap_pat [4] = '{0, 3, 0, 5};
    int           mphase;
    int           mbeats;
    logic [255:0] last_rd;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic int next_gap(input int k);
        if (use_pat) return gap_pat[k];
        return int'($urandom_range(0, 2));
    endfunction

    // Burst memory: beats delivered after per-beat gaps, reset together with the DUT.
    initial begin
        logic [255:0] ltmp;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        mbeat     = 0;
        gap_left  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !(mem_read || mem_write)) begin
                mbeat     = 0;
                gap_left  = next_gap(0);
                mem_resp  = stray_req;
                stray_req = 1'b0;
            end else if (gap_left > 0) begin
                gap_left--;
                mem_resp = 1'b0;
            end else if (mbeat < 4) begin
                mem_resp = 1'b1;
                if (mem_read) begin
                    ltmp      = mem_store.exists(mem_address) ? mem_store[mem_address] : '0;
                    mem_rdata = ltmp[mbeat*64 +: 64];
                end else begin
                    mem_rdata = {$urandom, $urandom};
                end
                mbeat++;
                if (mbeat < 4) gap_left = next_gap(mbeat);
            end else begin
                mem_resp = 1'b0;
            end
        end
    end

    // Monitor: pops the expected burst when one starts and checks it to completion.
    initial begin
        mphase  = 0;
        mbeats  = 0;
        last_rd = '0;
        cur     = '{kind: 0, addr: '0, line: '0};
        forever begin
            @(negedge clk);
            if (rst) begin
                mphase  = 0;
                last_rd = '0;
            end else if (mphase == 3) begin
                chk1("resp_one_cycle_i", i_pmem_resp, 1'b0);
                chk1("resp_one_cycle_d", d_pmem_resp, 1'b0);
                mphase = 0;
            end else if (mphase == 2) begin
                chk1("done_i_resp", i_pmem_resp, cur.kind == 0);
                chk1("done_d_resp", d_pmem_resp, cur.kind != 0);
                chk1("done_mem_read", mem_read, 1'b0);
                chk1("done_mem_write", mem_write, 1'b0);
                if (cur.kind != 2) last_rd = cur.line;
                chk("i_rdata", i_pmem_rdata, last_rd);
                chk("d_rdata", d_pmem_rdata, last_rd);
                mphase = 3;
            end else begin
                if (mphase == 0) begin
                    chk1("idle_i_resp", i_pmem_resp, 1'b0);
                    chk1("idle_d_resp", d_pmem_resp, 1'b0);
                    if (mem_read || mem_write) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_burst: got read=%0b write=%0b expected no burst",
                                     mem_read, mem_write);
                            cur = '{kind: 0, addr: '0, line: '0};
                        end else begin
                            cur = exp_q.pop_front();
                        end
                        chk1("burst_is_read", mem_read, cur.kind != 2);
                        chk1("burst_is_write", mem_write, cur.kind == 2);
                        chk("burst_addr", 256'(mem_address), 256'(cur.addr));
                        mphase = 1;
                        mbeats = 0;
                    end
                end
                if (mphase == 1) begin
                    chk("addr_stable", 256'(mem_address), 256'(cur.addr));
                    chk1("read_held", mem_read, cur.kind != 2);
                    chk1("write_held", mem_write, cur.kind == 2);
                    chk1("burst_no_i_resp", i_pmem_resp, 1'b0);
                    chk1("burst_no_d_resp", d_pmem_resp, 1'b0);
                    if (mem_resp) begin
                        if (cur.kind == 2)
                            chk("write_beat", 256'(mem_wdata), 256'(cur.line[mbeats*64 +: 64]));
                        mbeats++;
                        if (mbeats == 4) mphase = 2;
                    end
                end
            end
        end
    end

    // Issue one round of requests; contested rounds go to the loser of the last contest.
    task automatic run_round(input bit do_i, input bit do_d, input bit d_rd, input bit d_wr,
                             input logic [31:0] ia, input logic [31:0] da,
                             input logic [255:0] il, input logic [255:0] dl, input bit scramble);
        exp_t ei;
        exp_t ed;
        bit   d_first;
        bit   i_done;
        bit   d_done;
        int   cyc;
        ei.kind = 0;
        ei.addr = ia & 32'hFFFF_FFE0;
        ei.line = il;
        ed.kind = d_wr ? 2 : 1;
        ed.addr = da & 32'hFFFF_FFE0;
        ed.line = dl;
        if (do_i && do_d && !d_wr && ed.addr == ei.addr) ed.line = il;
        if (do_i) mem_store[ei.addr] = ei.line;
        if (do_d && !d_wr) mem_store[ed.addr] = ed.line;
        if (do_i && do_d) begin
            d_first = !last_d;
            last_d  = d_first;
            if (d_first) begin
                exp_q.push_back(ed);
                exp_q.push_back(ei);
            end else begin
                exp_q.push_back(ei);
                exp_q.push_back(ed);
            end
        end else if (do_i) begin
            exp_q.push_back(ei);
        end else if (do_d) begin
            exp_q.push_back(ed);
        end
        @(posedge clk);
        #2;
        i_pmem_read    = do_i;
        i_pmem_address = ia;
        d_pmem_read    = do_d & d_rd;
        d_pmem_write   = do_d & d_wr;
        d_pmem_address = da;
        d_pmem_wdata   = dl;
        i_done = !do_i;
        d_done = !do_d;
        cyc    = 0;
        while (!(i_done && d_done) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (!i_done && i_pmem_resp) begin
                i_done      = 1'b1;
                i_pmem_read = 1'b0;
            end
            if (!d_done && d_pmem_resp) begin
                d_done       = 1'b1;
                d_pmem_read  = 1'b0;
                d_pmem_write = 1'b0;
            end
            if (scramble && cyc == 2) begin
                i_pmem_address = $urandom;
                d_pmem_address = $urandom;
                d_pmem_wdata   = rand_line();
                i_pmem_read    = 1'b0;
                d_pmem_read    = 1'b0;
                d_pmem_write   = 1'b0;
            end
        end
        chk1("round_complete", i_done && d_done, 1'b1);
        i_pmem_read  = 1'b0;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [255:0] il;
        logic [255:0] dl;
        int           cyc;
        exp_t         e;
        rst            = 1'b1;
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        use_pat        = 1'b0;
        stray_req      = 1'b0;
        last_d         = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk1("reset_mem_read", mem_read, 1'b0);
        chk1("reset_mem_write", mem_write, 1'b0);
        chk1("reset_i_resp", i_pmem_resp, 1'b0);
        chk1("reset_d_resp", d_pmem_resp, 1'b0);
        chk("reset_mem_address", 256'(mem_address), 256'(0));
        chk("reset_i_rdata", i_pmem_rdata, 256'(0));
        chk("reset_d_rdata", d_pmem_rdata, 256'(0));

        // Contested out of reset: D first; the same contest again: I first.
        il = rand_line();
        dl = rand_line();
        run_round(1, 1, 1, 0, 32'h0000_2004, 32'h0000_3008, il, dl, 0);
        run_round(1, 1, 1, 0, 32'h0000_2004, 32'h0000_3008, il, dl, 0);

        // I-read of 0x1234 with recognisable beats.
        il = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        run_round(1, 0, 0, 0, 32'h0000_1234, 32'h0, il, '0, 0);

        // D-write of a byte ramp to 0x8000_0040.
        for (int b = 0; b < 32; b++) dl[b*8 +: 8] = 8'(b);
        run_round(0, 1, 0, 1, 32'h0, 32'h8000_0040, '0, dl, 0);

        // Irregular beat spacing.
        use_pat = 1'b1;
        run_round(1, 0, 0, 0, 32'h0000_7770, 32'h0, rand_line(), '0, 0);
        use_pat = 1'b0;

        // Read and write both high counts as a write.
        run_round(0, 1, 1, 1, 32'h0, 32'h0000_9abc, '0, rand_line(), 0);

        // Stray mem_resp while idle must not start or advance anything.
        @(posedge clk);
        #2 stray_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk1("stray_mem_read", mem_read, 1'b0);
            chk1("stray_mem_write", mem_write, 1'b0);
        end
        run_round(1, 0, 0, 0, 32'h0000_4440, 32'h0, rand_line(), '0, 0);

        // Reset after the second beat abandons the burst.
        il     = rand_line();
        e.kind = 0;
        e.addr = 32'h0000_5A40;
        e.line = il;
        mem_store[e.addr] = il;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_5A4C;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (mbeat < 2 && cyc < 100);
        chk1("rst_reach_beat2", mbeat >= 2, 1'b1);
        @(posedge clk);
        #2;
        rst         = 1'b1;
        i_pmem_read = 1'b0;
        exp_q.delete();
        last_d = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk1("rst_mid_mem_read", mem_read, 1'b0);
        chk1("rst_mid_mem_write", mem_write, 1'b0);
        chk("rst_mid_mem_address", 256'(mem_address), 256'(0));
        chk("rst_mid_i_rdata", i_pmem_rdata, 256'(0));
        repeat (6) begin
            @(negedge clk);
            chk1("rst_mid_no_i_resp", i_pmem_resp, 1'b0);
        end
        run_round(1, 0, 0, 0, 32'h0000_6620, 32'h0, rand_line(), '0, 0);

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            int sel;
            int op;
            bit sc;
            sel = int'($urandom_range(0, 2));
            op  = int'($urandom_range(0, 2));
            sc  = (sel != 2) && ($urandom_range(0, 1) == 1);
            run_round(sel != 1, sel != 0, op != 1, op != 0, $urandom, $urandom,
                      rand_line(), rand_line(), sc);
        end

        repeat (5) @(negedge clk);
        chk("exp_queue_drained", 256'(exp_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
